// File: rtl/tx_lane_serializer.sv
// Four-lane byte striper and MSB-first serializer feeding the receiver.
// Sends a COMMA preamble after reset, then round-robin lane slots.
module tx_lane_serializer #(
    parameter int          SYNC_BYTES = 4,
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter logic [7:0]  IDLE       = 8'h7C
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    output logic       salida_tx,
    output logic       ack0,
    output logic       ack1,
    output logic       ack2,
    output logic       ack3,
    output logic       tx_active
);

    typedef enum logic {
        SYNC,
        ACTIVE
    } state_e;

    localparam logic [3:0] SYNC_N = 4'(SYNC_BYTES);

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [1:0] lane_q;
    logic [3:0] pre_cnt_q;
    logic [6:0] shift_q;
    logic [3:0] ack_q;

    logic       sync_done;
    logic       lane_valid;
    logic [7:0] lane_data;
    logic [7:0] load_d;
    logic [3:0] ack_d;

    always_comb begin
        lane_valid = 1'b0;
        lane_data  = 8'h00;
        unique case (lane_q)
            2'd0: begin lane_valid = valid_in0; lane_data = in0; end
            2'd1: begin lane_valid = valid_in1; lane_data = in1; end
            2'd2: begin lane_valid = valid_in2; lane_data = in2; end
            2'd3: begin lane_valid = valid_in3; lane_data = in3; end
        endcase
    end

    // The slot right after the last comma is already an active slot.
    always_comb begin
        sync_done = (state_q == ACTIVE) || (pre_cnt_q == SYNC_N);
        load_d    = COMMA;
        ack_d     = 4'b0000;
        if (sync_done) begin
            load_d = lane_valid ? lane_data : IDLE;
            if (lane_valid)
                ack_d = 4'b0001 << lane_q;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (rst) begin
            state_q   <= SYNC;
            bit_cnt_q <= 3'd0;
            lane_q    <= 2'd0;
            pre_cnt_q <= 4'd0;
            shift_q   <= 7'd0;
            ack_q     <= 4'b0000;
            salida_tx <= 1'b0;
            tx_active <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            ack_q     <= 4'b0000;
            if (bit_cnt_q == 3'd0) begin
                salida_tx <= load_d[7];
                shift_q   <= load_d[6:0];
                ack_q     <= ack_d;
                if (sync_done) begin
                    state_q   <= ACTIVE;
                    tx_active <= 1'b1;
                    lane_q    <= lane_q + 2'd1;
                end else begin
                    pre_cnt_q <= pre_cnt_q + 4'd1;
                end
            end else begin
                salida_tx <= shift_q[6];
                shift_q   <= {shift_q[5:0], 1'b0};
            end
        end
    end

    assign ack0 = ack_q[0];
    assign ack1 = ack_q[1];
    assign ack2 = ack_q[2];
    assign ack3 = ack_q[3];

endmodule
